// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and default sizes for the SRAM bus arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : current bus owner, also exported on the owner status port
package sram_bus_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF       = 20;
  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned TA_CYCLES_DEF    = 1;
  localparam int unsigned CFC_WAIT_MAX_DEF = 800;
  // Turnaround counter width; TA_CYCLES is limited to 1..3
  localparam int unsigned TA_W             = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CFC_OWN = 2'd1,
    NFC_OWN = 2'd2,
    TURN    = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_CFC  = 2'b01,
    OWNER_NFC  = 2'b10
  } owner_t;

endpackage

// File: rtl/sram_bus_arbiter_port_mux.sv
// SRAM pin mux: passes the owning controller's address, write data and strobes
// straight through; with no owner, drives zeros and inactive (high) strobes.
//   owner_i             : current owner
//   cfc_* / nfc_*       : requester address, write data, we_n, oe_n
//   sram_*_o            : muxed SRAM address, write data, we_n, oe_n
module sram_bus_arbiter_port_mux
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  owner_t            owner_i,
  input  logic [ADDR_W-1:0] cfc_addr_i,
  input  logic [DATA_W-1:0] cfc_wdata_i,
  input  logic              cfc_we_n_i,
  input  logic              cfc_oe_n_i,
  input  logic [ADDR_W-1:0] nfc_addr_i,
  input  logic [DATA_W-1:0] nfc_wdata_i,
  input  logic              nfc_we_n_i,
  input  logic              nfc_oe_n_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  output logic              sram_we_n_o,
  output logic              sram_oe_n_o
);

  always_comb begin
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_we_n_o  = 1'b1;
    sram_oe_n_o  = 1'b1;
    case (owner_i)
      OWNER_CFC: begin
        sram_addr_o  = cfc_addr_i;
        sram_wdata_o = cfc_wdata_i;
        sram_we_n_o  = cfc_we_n_i;
        sram_oe_n_o  = cfc_oe_n_i;
      end
      OWNER_NFC: begin
        sram_addr_o  = nfc_addr_i;
        sram_wdata_o = nfc_wdata_i;
        sram_we_n_o  = nfc_we_n_i;
        sram_oe_n_o  = nfc_oe_n_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the single off-chip SRAM between the current-frame controller
// (CFC) and next-frame controller (NFC). Ownership only changes at the owner's
// step_done, with a TA_CYCLES idle gap between owners. CFC is never preempted.
//   Clk, Reset (sync, active-high)
//   cfc_req/nfc_req, cfc_step_done/nfc_step_done : requester handshake
//   cfc_en/nfc_en   : enable to the owning controller
//   cfc_*/nfc_* addr/wdata/we_n/oe_n -> SRAM_ADDRESS/Data_to_SRAM/SRAM_WE_N/SRAM_OE_N
//   owner           : 00 none, 01 CFC, 10 NFC
//   cfc_starved     : sticky, CFC waited more than CFC_WAIT_MAX cycles
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned TA_CYCLES    = TA_CYCLES_DEF,
  parameter int unsigned CFC_WAIT_MAX = CFC_WAIT_MAX_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cfc_req,
  input  logic              cfc_step_done,
  input  logic              nfc_req,
  input  logic              nfc_step_done,
  output logic              cfc_en,
  output logic              nfc_en,
  input  logic [ADDR_W-1:0] cfc_addr,
  input  logic [ADDR_W-1:0] nfc_addr,
  input  logic [DATA_W-1:0] cfc_wdata,
  input  logic [DATA_W-1:0] nfc_wdata,
  input  logic              cfc_we_n,
  input  logic              nfc_we_n,
  input  logic              cfc_oe_n,
  input  logic              nfc_oe_n,
  output logic [ADDR_W-1:0] SRAM_ADDRESS,
  output logic [DATA_W-1:0] Data_to_SRAM,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic [1:0]        owner,
  output logic              cfc_starved
);

  localparam int unsigned WAIT_W = $clog2(CFC_WAIT_MAX) + 1;

  arb_state_t        state_q,    state_d;
  arb_state_t        target_q,   target_d;
  logic [TA_W-1:0]   ta_cnt_q,   ta_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              starved_q,  starved_d;
  owner_t            owner_c;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      target_q   <= IDLE;
      ta_cnt_q   <= '0;
      wait_cnt_q <= '0;
      starved_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      ta_cnt_q   <= ta_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      starved_q  <= starved_d;
    end
  end

  // Next-state, turnaround counter and CFC starvation monitor
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    ta_cnt_d   = ta_cnt_q;
    wait_cnt_d = wait_cnt_q;
    starved_d  = starved_q;

    case (state_q)
      IDLE: begin
        if (cfc_req) begin
          state_d = CFC_OWN;
        end else if (nfc_req) begin
          state_d = NFC_OWN;
        end
      end
      CFC_OWN: begin
        // CFC releases only once it has no further work pending
        if (cfc_step_done && !cfc_req) begin
          if (nfc_req) begin
            state_d  = TURN;
            target_d = NFC_OWN;
            ta_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      NFC_OWN: begin
        // A waiting CFC takes the bus at NFC's next pause point
        if (nfc_step_done) begin
          if (cfc_req) begin
            state_d  = TURN;
            target_d = CFC_OWN;
            ta_cnt_d = '0;
          end else if (!nfc_req) begin
            state_d = IDLE;
          end
        end
      end
      TURN: begin
        if (ta_cnt_q == TA_W'(TA_CYCLES - 1)) begin
          state_d = target_q;
        end else begin
          ta_cnt_d = ta_cnt_q + TA_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == CFC_OWN) && (state_q != CFC_OWN)) begin
      wait_cnt_d = '0;
    end else if (cfc_req && (state_q != CFC_OWN) && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    if (wait_cnt_q > WAIT_W'(CFC_WAIT_MAX)) begin
      starved_d = 1'b1;
    end
  end

  // Status decoded from the registered state
  always_comb begin
    owner_c = OWNER_NONE;
    case (state_q)
      CFC_OWN: owner_c = OWNER_CFC;
      NFC_OWN: owner_c = OWNER_NFC;
      default: owner_c = OWNER_NONE;
    endcase
  end

  assign cfc_en      = (state_q == CFC_OWN);
  assign nfc_en      = (state_q == NFC_OWN);
  assign owner       = 2'(owner_c);
  assign cfc_starved = starved_q;

  sram_bus_arbiter_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .owner_i      (owner_c),
    .cfc_addr_i   (cfc_addr),
    .cfc_wdata_i  (cfc_wdata),
    .cfc_we_n_i   (cfc_we_n),
    .cfc_oe_n_i   (cfc_oe_n),
    .nfc_addr_i   (nfc_addr),
    .nfc_wdata_i  (nfc_wdata),
    .nfc_we_n_i   (nfc_we_n),
    .nfc_oe_n_i   (nfc_oe_n),
    .sram_addr_o  (SRAM_ADDRESS),
    .sram_wdata_o (Data_to_SRAM),
    .sram_we_n_o  (SRAM_WE_N),
    .sram_oe_n_o  (SRAM_OE_N)
  );

  // Bus invariants: never two owners, never strobes without an owner
  always @(posedge Clk) begin
    if (!Reset) begin
      assert (!(cfc_en && nfc_en));
      assert ((owner != 2'b00) || (SRAM_WE_N && SRAM_OE_N));
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  localparam int unsigned ADDR_W   = 20;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned TA       = 1;
  localparam int unsigned WAIT_MAX = 800;
  localparam int          WAIT_SAT = (1 << ($clog2(WAIT_MAX) + 1)) - 1;
  localparam int          VEC_W    = ADDR_W + DATA_W + 7;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              cfc_req = 1'b0, cfc_step_done = 1'b0;
  logic              nfc_req = 1'b0, nfc_step_done = 1'b0;
  logic              cfc_en, nfc_en;
  logic [ADDR_W-1:0] cfc_addr = '0, nfc_addr = '0;
  logic [DATA_W-1:0] cfc_wdata = '0, nfc_wdata = '0;
  logic              cfc_we_n = 1'b1, nfc_we_n = 1'b1;
  logic              cfc_oe_n = 1'b1, nfc_oe_n = 1'b1;
  logic [ADDR_W-1:0] SRAM_ADDRESS;
  logic [DATA_W-1:0] Data_to_SRAM;
  logic              SRAM_WE_N, SRAM_OE_N;
  logic [1:0]        owner;
  logic              cfc_starved;

  int checks = 0;
  int errors = 0;

  sram_bus_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .TA_CYCLES    (TA),
    .CFC_WAIT_MAX (WAIT_MAX)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .cfc_req       (cfc_req),
    .cfc_step_done (cfc_step_done),
    .nfc_req       (nfc_req),
    .nfc_step_done (nfc_step_done),
    .cfc_en        (cfc_en),
    .nfc_en        (nfc_en),
    .cfc_addr      (cfc_addr),
    .nfc_addr      (nfc_addr),
    .cfc_wdata     (cfc_wdata),
    .nfc_wdata     (nfc_wdata),
    .cfc_we_n      (cfc_we_n),
    .nfc_we_n      (nfc_we_n),
    .cfc_oe_n      (cfc_oe_n),
    .nfc_oe_n      (nfc_oe_n),
    .SRAM_ADDRESS  (SRAM_ADDRESS),
    .Data_to_SRAM  (Data_to_SRAM),
    .SRAM_WE_N     (SRAM_WE_N),
    .SRAM_OE_N     (SRAM_OE_N),
    .owner         (owner),
    .cfc_starved   (cfc_starved)
  );

  always #5 Clk = ~Clk;

  // Reference model: who holds the bus, remaining idle gap, and CFC wait time
  int m_owner   = 0;  // 0 none, 1 CFC, 2 NFC
  int m_gap     = 0;  // idle cycles still to run before m_target takes the bus
  int m_target  = 0;
  int m_wait    = 0;
  int m_starved = 0;
  int m_prev    = 0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_owner = 0; m_gap = 0; m_target = 0; m_wait = 0; m_starved = 0;
    end else begin
      m_prev = m_owner;
      if (m_wait > WAIT_MAX) m_starved = 1;
      if (m_gap > 0) begin
        m_gap = m_gap - 1;
        if (m_gap == 0) m_owner = m_target;
      end else if (m_owner == 0) begin
        if (cfc_req) m_owner = 1;
        else if (nfc_req) m_owner = 2;
      end else if (m_owner == 1) begin
        if (cfc_step_done && !cfc_req) begin
          m_owner = 0;
          if (nfc_req) begin m_gap = TA; m_target = 2; end
        end
      end else begin
        if (nfc_step_done && cfc_req) begin
          m_owner = 0; m_gap = TA; m_target = 1;
        end else if (nfc_step_done && !nfc_req) begin
          m_owner = 0;
        end
      end
      if (m_owner == 1 && m_prev != 1) m_wait = 0;
      else if (cfc_req && m_prev != 1 && m_wait < WAIT_SAT) m_wait = m_wait + 1;
    end
  end

  function automatic logic [VEC_W-1:0] model_vec();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              we, oe;
    a = '0; d = '0; we = 1'b1; oe = 1'b1;
    if (m_owner == 1) begin a = cfc_addr; d = cfc_wdata; we = cfc_we_n; oe = cfc_oe_n; end
    if (m_owner == 2) begin a = nfc_addr; d = nfc_wdata; we = nfc_we_n; oe = nfc_oe_n; end
    return {2'(m_owner), 1'(m_owner == 1), 1'(m_owner == 2), 1'(m_starved), we, oe, a, d};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_quiet();
    cfc_req = 1'b0; nfc_req = 1'b0; cfc_step_done = 1'b0; nfc_step_done = 1'b0;
    cfc_we_n = 1'b1; nfc_we_n = 1'b1; cfc_oe_n = 1'b1; nfc_oe_n = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive_quiet();
    cfc_we_n = 1'b0; nfc_oe_n = 1'b0;
    cfc_addr = ADDR_W'($urandom); nfc_addr = ADDR_W'($urandom);
    tick(); tick();
    checks++;
    if (owner !== 2'b00 || cfc_en !== 1'b0 || nfc_en !== 1'b0) begin
      errors++; $display("FAIL reset_owner: owner=%b cfc_en=%b nfc_en=%b, want 00 0 0", owner, cfc_en, nfc_en);
    end
    checks++;
    if (SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1 || SRAM_ADDRESS !== '0 || Data_to_SRAM !== '0) begin
      errors++; $display("FAIL reset_pins: we_n=%b oe_n=%b addr=%h data=%h, want 1 1 0 0", SRAM_WE_N, SRAM_OE_N, SRAM_ADDRESS, Data_to_SRAM);
    end
    checks++;
    if (cfc_starved !== 1'b0) begin
      errors++; $display("FAIL reset_starved: got %b want 0", cfc_starved);
    end
    drive_quiet();
  endtask

  task automatic test_tie();
    Reset = 1'b0;
    cfc_req = 1'b1; nfc_req = 1'b1;
    cfc_addr = ADDR_W'($urandom); cfc_wdata = DATA_W'($urandom);
    nfc_addr = ~cfc_addr;         nfc_wdata = ~cfc_wdata;
    tick();
    checks++;
    if (owner !== 2'b01 || cfc_en !== 1'b1 || nfc_en !== 1'b0) begin
      errors++; $display("FAIL tie_grant: owner=%b cfc_en=%b nfc_en=%b, want 01 1 0", owner, cfc_en, nfc_en);
    end
    checks++;
    if (SRAM_ADDRESS !== cfc_addr || Data_to_SRAM !== cfc_wdata) begin
      errors++; $display("FAIL tie_mux: addr=%h data=%h, want %h %h", SRAM_ADDRESS, Data_to_SRAM, cfc_addr, cfc_wdata);
    end
  endtask

  task automatic test_handoff();
    cfc_req = 1'b0; cfc_step_done = 1'b1; nfc_req = 1'b1;
    cfc_we_n = 1'b0; cfc_oe_n = 1'b0;
    #1;
    checks++;
    if (cfc_en !== 1'b1) begin
      errors++; $display("FAIL handoff_en_held: cfc_en=%b want 1", cfc_en);
    end
    tick();
    cfc_step_done = 1'b0;
    checks++;
    if (owner !== 2'b00 || SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1 || cfc_en !== 1'b0 || nfc_en !== 1'b0) begin
      errors++; $display("FAIL handoff_turn: owner=%b we_n=%b oe_n=%b en=%b%b, want 00 1 1 00", owner, SRAM_WE_N, SRAM_OE_N, cfc_en, nfc_en);
    end
    nfc_addr = ADDR_W'($urandom); nfc_we_n = 1'($urandom); nfc_oe_n = ~nfc_we_n;
    tick();
    checks++;
    if (owner !== 2'b10 || nfc_en !== 1'b1 || SRAM_ADDRESS !== nfc_addr || SRAM_WE_N !== nfc_we_n || SRAM_OE_N !== nfc_oe_n) begin
      errors++; $display("FAIL handoff_nfc: owner=%b nfc_en=%b addr=%h we_n=%b, want 10 1 %h %b", owner, nfc_en, SRAM_ADDRESS, SRAM_WE_N, nfc_addr, nfc_we_n);
    end
    cfc_we_n = 1'b1; cfc_oe_n = 1'b1; nfc_we_n = 1'b1; nfc_oe_n = 1'b1;
  endtask

  task automatic test_nfc_hold();
    int lost;
    lost = 0;
    cfc_req = 1'b1; cfc_step_done = 1'b1; nfc_step_done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (owner !== 2'b10) lost++;
    end
    checks++;
    if (lost !== 0) begin
      errors++; $display("FAIL hold_nfc: cycles not owned by NFC=%0d want 0", lost);
    end
    cfc_step_done = 1'b0; nfc_step_done = 1'b1;
    tick();
    nfc_step_done = 1'b0;
    checks++;
    if (owner !== 2'b00) begin
      errors++; $display("FAIL hold_turn: owner=%b want 00", owner);
    end
    tick();
    checks++;
    if (owner !== 2'b01 || cfc_en !== 1'b1 || cfc_starved !== 1'b0) begin
      errors++; $display("FAIL hold_cfc: owner=%b cfc_en=%b starved=%b, want 01 1 0", owner, cfc_en, cfc_starved);
    end
  endtask

  task automatic test_starvation();
    cfc_req = 1'b0; cfc_step_done = 1'b1; nfc_req = 1'b1;
    tick();
    cfc_step_done = 1'b0;
    tick();
    checks++;
    if (owner !== 2'b10) begin
      errors++; $display("FAIL starve_setup: owner=%b want 10", owner);
    end
    cfc_req = 1'b1;
    repeat (795) tick();
    checks++;
    if (cfc_starved !== 1'b0) begin
      errors++; $display("FAIL starve_early: starved=%b want 0 after 795 waiting cycles", cfc_starved);
    end
    repeat (10) tick();
    checks++;
    if (cfc_starved !== 1'b1) begin
      errors++; $display("FAIL starve_set: starved=%b want 1 after 805 waiting cycles", cfc_starved);
    end
    nfc_step_done = 1'b1;
    tick();
    nfc_step_done = 1'b0;
    tick();
    checks++;
    if (owner !== 2'b01 || cfc_starved !== 1'b1) begin
      errors++; $display("FAIL starve_granted: owner=%b starved=%b want 01 1", owner, cfc_starved);
    end
    cfc_req = 1'b0; nfc_req = 1'b0; cfc_step_done = 1'b1;
    tick();
    cfc_step_done = 1'b0;
    checks++;
    if (owner !== 2'b00 || cfc_starved !== 1'b1) begin
      errors++; $display("FAIL starve_sticky: owner=%b starved=%b want 00 1", owner, cfc_starved);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (cfc_starved !== 1'b0) begin
      errors++; $display("FAIL starve_clear: starved=%b want 0", cfc_starved);
    end
  endtask

  task automatic test_reset_mid();
    drive_quiet();
    cfc_req = 1'b1;
    tick();
    cfc_req = 1'b0; cfc_step_done = 1'b1; nfc_req = 1'b1;
    tick();
    cfc_step_done = 1'b0;
    checks++;
    if (owner !== 2'b00) begin
      errors++; $display("FAIL rst_turn_setup: owner=%b want 00", owner);
    end
    Reset = 1'b1; nfc_we_n = 1'b0;
    tick();
    checks++;
    if (owner !== 2'b00 || cfc_en !== 1'b0 || nfc_en !== 1'b0 || SRAM_WE_N !== 1'b1) begin
      errors++; $display("FAIL rst_turn: owner=%b en=%b%b we_n=%b, want 00 00 1", owner, cfc_en, nfc_en, SRAM_WE_N);
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (owner !== 2'b10 || SRAM_WE_N !== 1'b0) begin
      errors++; $display("FAIL rst_nfc_setup: owner=%b we_n=%b want 10 0", owner, SRAM_WE_N);
    end
    Reset = 1'b1;
    tick();
    checks++;
    if (owner !== 2'b00 || cfc_en !== 1'b0 || nfc_en !== 1'b0 || SRAM_WE_N !== 1'b1) begin
      errors++; $display("FAIL rst_nfc: owner=%b en=%b%b we_n=%b, want 00 00 1", owner, cfc_en, nfc_en, SRAM_WE_N);
    end
    Reset = 1'b0;
    drive_quiet();
  endtask

  task automatic test_random();
    logic [VEC_W-1:0] got, exp;
    for (int i = 0; i < 20000; i++) begin
      Reset         = ($urandom_range(0, 999) == 0);
      cfc_req       = ($urandom_range(0, 3) == 0);
      nfc_req       = ($urandom_range(0, 1) == 0);
      cfc_step_done = ($urandom_range(0, 2) == 0);
      nfc_step_done = ($urandom_range(0, 4) == 0);
      cfc_addr  = ADDR_W'($urandom); nfc_addr  = ADDR_W'($urandom);
      cfc_wdata = DATA_W'($urandom); nfc_wdata = DATA_W'($urandom);
      cfc_we_n  = 1'($urandom);      nfc_we_n  = 1'($urandom);
      cfc_oe_n  = 1'($urandom);      nfc_oe_n  = 1'($urandom);
      tick();
      got = {owner, cfc_en, nfc_en, cfc_starved, SRAM_WE_N, SRAM_OE_N, SRAM_ADDRESS, Data_to_SRAM};
      exp = model_vec();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random_cycle%0d: got %h want %h", i, got, exp);
      end
      checks++;
      if ((cfc_en && nfc_en) || (owner == 2'b00 && (!SRAM_WE_N || !SRAM_OE_N))) begin
        errors++; $display("FAIL random_invariant%0d: en=%b%b owner=%b we_n=%b oe_n=%b", i, cfc_en, nfc_en, owner, SRAM_WE_N, SRAM_OE_N);
      end
    end
    Reset = 1'b0;
    drive_quiet();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_handoff();
    test_nfc_hold();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
